// File: rtl/mem_stage_wait.sv
// mem_stage_wait: MEM stage with wait-state data memory, freeze output and MEM/WB register
module mem_stage_wait #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_en_in,
  input  logic              MEM_r_en_in,
  input  logic              MEM_w_en_in,
  input  logic [3:0]        dest_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] val_rm,
  output logic              freeze,
  output logic              WB_en_out,
  output logic              MEM_r_en_out,
  output logic [3:0]        dest_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [DATA_W-1:0] data_mem_out,
  output logic              addr_err
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(WAIT_CYCLES + 1) + 1;
  localparam logic [CW-1:0] WC = CW'(WAIT_CYCLES);
  localparam logic [DATA_W-1:0] LO = DATA_W'(BASE_ADDR);
  localparam logic [DATA_W-1:0] HI = DATA_W'(BASE_ADDR + 4 * DEPTH);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic req, store, load, done, in_range;
  logic [IW-1:0] idx;
  logic [DATA_W-1:0] mem [DEPTH];
  assign req = MEM_r_en_in | MEM_w_en_in;
  assign store = MEM_w_en_in;
  assign load = MEM_r_en_in & ~MEM_w_en_in;
  assign idx = IW'((alu_res_in - LO) >> 2);
  assign in_range = alu_res_in >= LO && alu_res_in < HI;
  // wait-state FSM register; a reset mid-access drops back to IDLE
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  // next state: count wait cycles from 1 up to WAIT_CYCLES, then release
  always_comb begin
    state_nx = state == IDLE ? (req && WAIT_CYCLES > 0 ? BUSY : IDLE) : (cnt == WC ? IDLE : BUSY);
    cnt_nx = state_nx == BUSY ? cnt + CW'(1) : '0;
  end
  // freeze holds upstream until the access completes in the final cycle
  always_comb begin
    freeze = state == BUSY ? cnt != WC : req && WAIT_CYCLES > 0;
    done = state == BUSY ? req && cnt == WC : req && WAIT_CYCLES == 0;
  end
  // store commits once, on the completion edge, only when in range
  always_ff @(posedge clk)
    if (done && store && in_range) mem[idx] <= val_rm;
  // MEM/WB register: bubbles while frozen, load data only on completing loads
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      WB_en_out <= 1'b0;
      MEM_r_en_out <= 1'b0;
      dest_out <= '0;
      alu_res_out <= '0;
      data_mem_out <= '0;
      addr_err <= 1'b0;
    end else begin
      WB_en_out <= WB_en_in & ~freeze;
      MEM_r_en_out <= MEM_r_en_in & ~freeze;
      addr_err <= done & ~in_range;
      if (!freeze) begin
        dest_out <= dest_in;
        alu_res_out <= alu_res_in;
      end
      if (done && load) data_mem_out <= in_range ? mem[idx] : '0;
    end
endmodule
